// File: rtl/clk_step_ctrl.sv
// Clock-enable and reset controller for the turtle CPU: conditions the board
// inputs, stretches CPU reset and issues bursts of single-cycle enables in manual mode.
module clk_step_ctrl #(
  parameter int DEBOUNCE_CYCLES      = 16,
  parameter int BURST_WIDTH          = 8,
  parameter int RESET_STRETCH_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reset_btn,
  input  logic                   manual_clk_sw,
  input  logic                   pulse_clk_btn,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   cpu_clk_en,
  output logic                   cpu_reset,
  output logic                   manual_mode,
  output logic                   busy,
  output logic [BURST_WIDTH-1:0] burst_remaining
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(RESET_STRETCH_CYCLES + 1);

  typedef enum logic [1:0] {
    RESET_HOLD,
    AUTO,
    MANUAL_IDLE,
    BURST
  } state_t;

  logic [2:0] raw_bus;
  logic [2:0] db_bus;

  assign raw_bus = {pulse_clk_btn, manual_clk_sw, reset_btn};

  // Per input: 2-flop synchroniser, then a flip only after DEBOUNCE_CYCLES+1
  // consecutive differing samples (counter saturates at DEBOUNCE_CYCLES first).
  for (genvar gi = 0; gi < 3; gi++) begin : g_cond
    logic            sync1_reg;
    logic            sync2_reg;
    logic            db_reg;
    logic [DB_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        db_reg    <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        sync1_reg <= raw_bus[gi];
        sync2_reg <= sync1_reg;
        if (sync2_reg == db_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES)) begin
          db_reg  <= ~db_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end
    end

    assign db_bus[gi] = db_reg;
  end

  logic rst_db;
  logic mode_db;
  logic pulse_db;
  logic pulse_prev_reg;
  logic pulse_event;

  assign rst_db      = db_bus[0];
  assign mode_db     = db_bus[1];
  assign pulse_db    = db_bus[2];
  assign pulse_event = pulse_db & ~pulse_prev_reg;

  state_t                 state_reg;
  logic [ST_W-1:0]        stretch_reg;
  logic [BURST_WIDTH-1:0] remaining_reg;
  logic [BURST_WIDTH-1:0] burst_load;

  assign burst_load = (burst_len == '0) ? BURST_WIDTH'(1) : burst_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RESET_HOLD;
      stretch_reg    <= ST_W'(RESET_STRETCH_CYCLES);
      remaining_reg  <= '0;
      pulse_prev_reg <= 1'b0;
    end else begin
      pulse_prev_reg <= pulse_db;
      if (rst_db) begin
        state_reg     <= RESET_HOLD;
        stretch_reg   <= ST_W'(RESET_STRETCH_CYCLES);
        remaining_reg <= '0;
      end else begin
        case (state_reg)
          RESET_HOLD: begin
            // Leave on the edge where the count would reach zero, so the
            // CPU sees exactly RESET_STRETCH_CYCLES reset cycles after release.
            if (stretch_reg <= ST_W'(1)) begin
              stretch_reg <= '0;
              state_reg   <= mode_db ? MANUAL_IDLE : AUTO;
            end else begin
              stretch_reg <= stretch_reg - ST_W'(1);
            end
          end
          AUTO: begin
            if (mode_db) state_reg <= MANUAL_IDLE;
          end
          MANUAL_IDLE: begin
            if (!mode_db) begin
              state_reg <= AUTO;
            end else if (pulse_event) begin
              state_reg     <= BURST;
              remaining_reg <= burst_load;
            end
          end
          BURST: begin
            if (!mode_db) begin
              state_reg     <= AUTO;
              remaining_reg <= '0;
            end else if (remaining_reg == BURST_WIDTH'(1)) begin
              state_reg     <= MANUAL_IDLE;
              remaining_reg <= '0;
            end else begin
              remaining_reg <= remaining_reg - BURST_WIDTH'(1);
            end
          end
          default: state_reg <= RESET_HOLD;
        endcase
      end
    end
  end

  assign cpu_reset       = (state_reg == RESET_HOLD);
  assign cpu_clk_en      = (state_reg != MANUAL_IDLE);
  assign busy            = (state_reg == BURST);
  assign manual_mode     = mode_db;
  assign burst_remaining = remaining_reg;

endmodule
